// File: rtl/nn_input_loader.sv
// Collects one frame of grayscale pixels into a shadow buffer as Q8.8 values, then publishes the
// buffer to NNin with a one-cycle NNvalid pulse. NNin holds its value until the next frame completes.
module nn_input_loader #(
  parameter int unsigned numInputs  = 784,
  parameter int unsigned pixelWidth = 8,
  parameter int unsigned dataWidth  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [pixelWidth-1:0]           pixIn,
  input  logic                            pixValid,
  input  logic                            pixSof,
  output logic                            pixReady,
  output logic [numInputs*dataWidth-1:0]  NNin,
  output logic                            NNvalid,
  output logic [15:0]                     frameCount,
  output logic                            frameErr
);

  localparam int unsigned CountWidth = $clog2(numInputs + 1);
  localparam logic [CountWidth-1:0] LastIdx = CountWidth'(numInputs - 1);

  typedef enum logic [1:0] {StIdle, StFill, StPublish} state_e;

  state_e                         state_q;
  logic [CountWidth-1:0]          count_q;
  logic [numInputs*dataWidth-1:0] shadow_q;
  logic                           publish_q;

  logic                  accept;
  logic                  write_en;
  logic [CountWidth-1:0] wr_idx;
  logic [dataWidth-1:0]  pix_q88;

  assign pixReady = (state_q != StPublish);
  assign accept   = pixValid & pixReady;
  // A start-of-frame pixel always lands at index 0; in IDLE only such a pixel is stored.
  assign write_en = accept & (pixSof | (state_q == StFill));
  assign wr_idx   = pixSof ? '0 : count_q;
  assign pix_q88  = dataWidth'(pixIn);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      shadow_q   <= '0;
      NNin       <= '0;
      publish_q  <= 1'b0;
      NNvalid    <= 1'b0;
      frameCount <= '0;
      frameErr   <= 1'b0;
    end else begin
      frameErr  <= 1'b0;
      publish_q <= 1'b0;
      // NNvalid trails the NNin load by one cycle so NNin is already settled when it rises.
      NNvalid   <= publish_q;
      unique case (state_q)
        StIdle, StFill: begin
          if (write_en) begin
            shadow_q[wr_idx*dataWidth +: dataWidth] <= pix_q88;
            frameErr <= pixSof & (state_q == StFill);
            if (wr_idx == LastIdx) begin
              state_q <= StPublish;
              count_q <= '0;
            end else begin
              state_q <= StFill;
              count_q <= wr_idx + 1'b1;
            end
          end
        end
        StPublish: begin
          NNin       <= shadow_q;
          publish_q  <= 1'b1;
          frameCount <= frameCount + 16'd1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
